// File: rtl/fim_reset_sequencer.sv
// fim_reset_sequencer: staged reset release for the FPGA interface manager.
// clk, rst_n          : sequencer clock, async active-low reset
// ninit_done          : device init-done (active-low, async)
// pll_locked          : system IOPLL lock (async)
// pcie_perst_n        : PCIe PERST# (active-low, async)
// soft_reset_req      : sync pulse requesting a full re-sequence
// ss_ready[NUM_SS]    : per-subsystem ready/ack
// ss_rst_n[NUM_SS]    : per-subsystem reset, released in index order
// afu_rst_n           : AFU/port reset, released last
// seq_done            : high while in RUN
// timeout_err[NUM_SS] : sticky per-subsystem ack-timeout flags
// seq_state           : current state encoding
module fim_reset_sequencer #(
    parameter int NUM_SS      = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ninit_done,
    input  logic              pll_locked,
    input  logic              pcie_perst_n,
    input  logic              soft_reset_req,
    input  logic [NUM_SS-1:0] ss_ready,
    output logic [NUM_SS-1:0] ss_rst_n,
    output logic              afu_rst_n,
    output logic              seq_done,
    output logic [NUM_SS-1:0] timeout_err,
    output logic [2:0]        seq_state
);
    localparam int IW = NUM_SS > 1 ? $clog2(NUM_SS) : 1;
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int TW = $clog2(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        WAIT_READY = 3'd1,
        HOLD       = 3'd2,
        SS_REL     = 3'd3,
        SS_WAIT    = 3'd4,
        AFU_REL    = 3'd5,
        RUN        = 3'd6
    } state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic [HW-1:0]     hold_cnt, hold_cnt_nx;
    logic [TW-1:0]     timer, timer_nx;
    logic [NUM_SS-1:0] ss_rst_n_nx, timeout_err_nx;
    logic              afu_rst_n_nx, seq_done_nx;
    logic [1:0]        ninit_q, pll_q, perst_q;
    logic              ok, abort, expired;

    // synchronizers reset to the "not ready" level so a fresh reset never looks ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ninit_q <= 2'b11;
            pll_q   <= 2'b00;
            perst_q <= 2'b00;
        end else begin
            ninit_q <= {ninit_q[0], ninit_done};
            pll_q   <= {pll_q[0], pll_locked};
            perst_q <= {perst_q[0], pcie_perst_n};
        end
    end

    assign ok        = !ninit_q[1] & pll_q[1] & perst_q[1];
    assign abort     = (state != WAIT_READY) & (!ok | soft_reset_req);
    assign expired   = timer == TW'(ACK_TIMEOUT - 1);
    assign seq_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_READY;
            idx         <= '0;
            hold_cnt    <= '0;
            timer       <= '0;
            ss_rst_n    <= '0;
            afu_rst_n   <= 1'b0;
            seq_done    <= 1'b0;
            timeout_err <= '0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            hold_cnt    <= hold_cnt_nx;
            timer       <= timer_nx;
            ss_rst_n    <= ss_rst_n_nx;
            afu_rst_n   <= afu_rst_n_nx;
            seq_done    <= seq_done_nx;
            timeout_err <= timeout_err_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        idx_nx         = idx;
        hold_cnt_nx    = hold_cnt;
        timer_nx       = timer;
        ss_rst_n_nx    = ss_rst_n;
        afu_rst_n_nx   = afu_rst_n;
        seq_done_nx    = seq_done;
        timeout_err_nx = timeout_err;
        if (abort) begin
            // abort wins over any same-cycle ready or advance
            state_nx     = WAIT_READY;
            idx_nx       = '0;
            hold_cnt_nx  = '0;
            timer_nx     = '0;
            ss_rst_n_nx  = '0;
            afu_rst_n_nx = 1'b0;
            seq_done_nx  = 1'b0;
        end else begin
            case (state)
                WAIT_READY: begin
                    ss_rst_n_nx  = '0;
                    afu_rst_n_nx = 1'b0;
                    seq_done_nx  = 1'b0;
                    if (ok) begin
                        state_nx       = HOLD;
                        hold_cnt_nx    = '0;
                        timeout_err_nx = '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        state_nx = SS_REL;
                        idx_nx   = '0;
                    end else begin
                        hold_cnt_nx = hold_cnt + HW'(1);
                    end
                end
                SS_REL: begin
                    ss_rst_n_nx[idx] = 1'b1;
                    timer_nx         = '0;
                    state_nx         = SS_WAIT;
                end
                SS_WAIT: begin
                    if (ss_ready[idx] || expired) begin
                        if (!ss_ready[idx]) timeout_err_nx[idx] = 1'b1;
                        state_nx = idx == IW'(NUM_SS - 1) ? AFU_REL : SS_REL;
                        idx_nx   = idx == IW'(NUM_SS - 1) ? idx : idx + IW'(1);
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
                AFU_REL: begin
                    afu_rst_n_nx = 1'b1;
                    seq_done_nx  = 1'b1;
                    state_nx     = RUN;
                end
                RUN: ;
                default: state_nx = WAIT_READY;
            endcase
        end
    end
endmodule

// File: tb/tb_fim_reset_sequencer.sv
// tb_fim_reset_sequencer: directed vector bench for fim_reset_sequencer.
module tb_fim_reset_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ninit_done, pll_locked, pcie_perst_n, soft_reset_req;
    logic [2:0] ss_ready, ss_rst_n, timeout_err;
    logic       afu_rst_n, seq_done;
    logic [2:0] seq_state;
    int         passed = 0;
    int         total = 0;

    fim_reset_sequencer #(.NUM_SS(3), .HOLD_CYCLES(16), .ACK_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .ninit_done(ninit_done), .pll_locked(pll_locked),
        .pcie_perst_n(pcie_perst_n), .soft_reset_req(soft_reset_req), .ss_ready(ss_ready),
        .ss_rst_n(ss_rst_n), .afu_rst_n(afu_rst_n), .seq_done(seq_done),
        .timeout_err(timeout_err), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    // in = {ninit_done, pll_locked, pcie_perst_n, soft_reset_req}, ad = {afu_rst_n, seq_done}
    typedef struct {
        logic [3:0] in;
        logic [2:0] rdy;
        int         cyc;
        logic [2:0] ss;
        logic [1:0] ad;
        logic [2:0] st;
        logic [2:0] te;
    } vec_t;

    localparam logic [3:0] RDY = 4'b0110, SOFT = 4'b0111, NOPERST = 4'b0100, NOPLL = 4'b0010;

    vec_t vq[$];

    function automatic vec_t mk(logic [3:0] in, logic [2:0] rdy, int cyc, logic [2:0] ss,
                                logic [1:0] ad, logic [2:0] st, logic [2:0] te);
        vec_t v;
        v.in = in; v.rdy = rdy; v.cyc = cyc; v.ss = ss; v.ad = ad; v.st = st; v.te = te;
        return v;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic chk_all(string tag, logic [2:0] ss, logic [1:0] ad, logic [2:0] st, logic [2:0] te);
        chk({tag, " ss_rst_n"}, 8'(ss_rst_n), 8'(ss));
        chk({tag, " afu/done"}, 8'({afu_rst_n, seq_done}), 8'(ad));
        chk({tag, " seq_state"}, 8'(seq_state), 8'(st));
        chk({tag, " timeout_err"}, 8'(timeout_err), 8'(te));
    endtask

    initial begin
        // normal bring-up, ready 5 cycles after each release
        vq.push_back(mk(RDY, 3'b000, 3,  3'b000, 2'b00, 3'd2, 3'b000));
        vq.push_back(mk(RDY, 3'b000, 16, 3'b000, 2'b00, 3'd3, 3'b000));
        vq.push_back(mk(RDY, 3'b000, 1,  3'b001, 2'b00, 3'd4, 3'b000));
        vq.push_back(mk(RDY, 3'b000, 4,  3'b001, 2'b00, 3'd4, 3'b000));
        vq.push_back(mk(RDY, 3'b001, 1,  3'b001, 2'b00, 3'd3, 3'b000));
        vq.push_back(mk(RDY, 3'b001, 1,  3'b011, 2'b00, 3'd4, 3'b000));
        vq.push_back(mk(RDY, 3'b001, 4,  3'b011, 2'b00, 3'd4, 3'b000));
        vq.push_back(mk(RDY, 3'b011, 1,  3'b011, 2'b00, 3'd3, 3'b000));
        vq.push_back(mk(RDY, 3'b011, 1,  3'b111, 2'b00, 3'd4, 3'b000));
        vq.push_back(mk(RDY, 3'b011, 4,  3'b111, 2'b00, 3'd4, 3'b000));
        vq.push_back(mk(RDY, 3'b111, 1,  3'b111, 2'b00, 3'd5, 3'b000));
        vq.push_back(mk(RDY, 3'b111, 1,  3'b111, 2'b11, 3'd6, 3'b000));
        vq.push_back(mk(RDY, 3'b111, 10, 3'b111, 2'b11, 3'd6, 3'b000));
        // soft reset from RUN, then a soft pulse in WAIT_READY is ignored
        vq.push_back(mk(SOFT, 3'b000, 1,  3'b000, 2'b00, 3'd1, 3'b000));
        vq.push_back(mk(SOFT, 3'b000, 1,  3'b000, 2'b00, 3'd2, 3'b000));
        vq.push_back(mk(RDY,  3'b000, 16, 3'b000, 2'b00, 3'd3, 3'b000));
        vq.push_back(mk(RDY,  3'b000, 1,  3'b001, 2'b00, 3'd4, 3'b000));
        // ss_ready[1] never comes; ss_ready[2] high early must be ignored
        vq.push_back(mk(RDY, 3'b001, 1,  3'b001, 2'b00, 3'd3, 3'b000));
        vq.push_back(mk(RDY, 3'b001, 1,  3'b011, 2'b00, 3'd4, 3'b000));
        vq.push_back(mk(RDY, 3'b101, 63, 3'b011, 2'b00, 3'd4, 3'b000));
        vq.push_back(mk(RDY, 3'b101, 1,  3'b011, 2'b00, 3'd3, 3'b010));
        vq.push_back(mk(RDY, 3'b101, 1,  3'b111, 2'b00, 3'd4, 3'b010));
        vq.push_back(mk(RDY, 3'b101, 1,  3'b111, 2'b00, 3'd5, 3'b010));
        vq.push_back(mk(RDY, 3'b101, 1,  3'b111, 2'b11, 3'd6, 3'b010));
        // PERST# drop in RUN, abort on the third edge, timeout_err clears on HOLD entry
        vq.push_back(mk(NOPERST, 3'b000, 2, 3'b111, 2'b11, 3'd6, 3'b010));
        vq.push_back(mk(NOPERST, 3'b000, 1, 3'b000, 2'b00, 3'd1, 3'b010));
        vq.push_back(mk(RDY, 3'b000, 2,  3'b000, 2'b00, 3'd1, 3'b010));
        vq.push_back(mk(RDY, 3'b000, 1,  3'b000, 2'b00, 3'd2, 3'b000));
        vq.push_back(mk(RDY, 3'b000, 15, 3'b000, 2'b00, 3'd2, 3'b000));
        vq.push_back(mk(RDY, 3'b000, 1,  3'b000, 2'b00, 3'd3, 3'b000));
        vq.push_back(mk(RDY, 3'b000, 1,  3'b001, 2'b00, 3'd4, 3'b000));
        vq.push_back(mk(RDY, 3'b001, 1,  3'b001, 2'b00, 3'd3, 3'b000));
        vq.push_back(mk(RDY, 3'b000, 1,  3'b011, 2'b00, 3'd4, 3'b000));
        // soft reset in SS_WAIT with idx=1, re-sequence, then pll glitch at hold_cnt=10
        vq.push_back(mk(SOFT, 3'b000, 1,  3'b000, 2'b00, 3'd1, 3'b000));
        vq.push_back(mk(RDY,  3'b000, 1,  3'b000, 2'b00, 3'd2, 3'b000));
        vq.push_back(mk(RDY,  3'b000, 10, 3'b000, 2'b00, 3'd2, 3'b000));
        vq.push_back(mk(NOPLL, 3'b000, 2, 3'b000, 2'b00, 3'd2, 3'b000));
        vq.push_back(mk(RDY,  3'b000, 1,  3'b000, 2'b00, 3'd1, 3'b000));
        vq.push_back(mk(RDY,  3'b000, 1,  3'b000, 2'b00, 3'd1, 3'b000));
        vq.push_back(mk(RDY,  3'b000, 1,  3'b000, 2'b00, 3'd2, 3'b000));
        vq.push_back(mk(RDY,  3'b000, 15, 3'b000, 2'b00, 3'd2, 3'b000));
        vq.push_back(mk(RDY,  3'b000, 1,  3'b000, 2'b00, 3'd3, 3'b000));
        vq.push_back(mk(RDY,  3'b000, 1,  3'b001, 2'b00, 3'd4, 3'b000));

        rst_n = 1'b0;
        {ninit_done, pll_locked, pcie_perst_n, soft_reset_req} = 4'b1000;
        ss_ready = 3'b000;
        repeat (2) @(negedge clk);
        chk_all("reset", 3'b000, 2'b00, 3'd1, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        soft_reset_req = 1'b1;
        @(negedge clk);
        soft_reset_req = 1'b0;
        chk("soft_in_wait seq_state", 8'(seq_state), 8'd1);

        for (int i = 0; i < vq.size(); i++) begin
            {ninit_done, pll_locked, pcie_perst_n, soft_reset_req} = vq[i].in;
            ss_ready = vq[i].rdy;
            repeat (vq[i].cyc) @(negedge clk);
            chk_all($sformatf("v%0d", i), vq[i].ss, vq[i].ad, vq[i].st, vq[i].te);
        end

        // async reset mid-SS_WAIT takes effect without a clock edge
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 3'b000, 2'b00, 3'd1, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst sync seq_state", 8'(seq_state), 8'd1);
        @(negedge clk);
        chk("post_rst hold seq_state", 8'(seq_state), 8'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fim_reset_sequencer.md
# fim_reset_sequencer

Reset sequencer for the FPGA interface manager. Waits for device init done, system PLL lock and PCIe PERST# deassertion. Then releases the subsystem resets (PCIe SS, memory SS, HSSI SS, in index order) one at a time, waiting for each subsystem's ready/ack. It releases the AFU/port reset last. It sits beside the top-level reset logic, between the board reset/clock inputs and the subsystem reset pins.

## Interface
Parameters:
- NUM_SS, 3: number of sequenced subsystems; release order is index 0..NUM_SS-1.
- HOLD_CYCLES, 16: cycles the start condition must hold stable before the first release; ≥2.
- ACK_TIMEOUT, 1024: maximum cycles spent waiting for one subsystem ready; ≥2.

Ports:
- clk  in  1  sequencer clock.
- rst_n  in  1  asynchronous, active-low reset.
- ninit_done  in  1  device init-done, active-low; asynchronous, synchronized internally.
- pll_locked  in  1  system IOPLL lock; asynchronous, synchronized internally.
- pcie_perst_n  in  1  PCIe PERST#, active-low; asynchronous, synchronized internally.
- soft_reset_req  in  1  synchronous pulse requesting a full re-sequence.
- ss_ready  in  NUM_SS  per-subsystem ready/ack (calibration done, link ready, ...); synchronous to clk.
- ss_rst_n  out  NUM_SS  per-subsystem reset, active-low.
- afu_rst_n  out  1  AFU/port reset, active-low.
- seq_done  out  1  high while in RUN.
- timeout_err  out  NUM_SS  sticky per-subsystem ack-timeout flags.
- seq_state  out  3  current state encoding, for debug/CSR.

## Operation
- Synchronizers: each async input passes through a 2-flop synchronizer. The synchronizer reset value is the "not ready" level: ninit_done→1, pll_locked→0, pcie_perst_n→0.
- ok = !ninit_done_s & pll_locked_s & pcie_perst_n_s.
- States and seq_state encoding: WAIT_READY=1, HOLD=2, SS_REL=3, SS_WAIT=4, AFU_REL=5, RUN=6. Encoding 0 is unused.
- Reset values (async on rst_n low): state WAIT_READY, all ss_rst_n=0, afu_rst_n=0, seq_done=0, timeout_err=0, idx=0, counters=0.
- WAIT_READY: all resets held asserted. When ok=1, go to HOLD with hold_cnt=0, and clear timeout_err.
- HOLD: hold_cnt increments each cycle. When hold_cnt==HOLD_CYCLES-1 with ok still 1, go to SS_REL with idx=0.
- SS_REL: set ss_rst_n[idx]=1, clear the wait timer, go to SS_WAIT.
- SS_WAIT:
  - If ss_ready[idx]=1, advance.
  - Else if timer==ACK_TIMEOUT-1, set timeout_err[idx]=1 and advance.
  - Else increment the timer.
  - Advance means: if idx==NUM_SS-1 go to AFU_REL, else idx+1 and go to SS_REL.
  - Only ss_ready[idx] is examined; other ready bits are ignored.
  - A timeout does not stop the sequence.
- AFU_REL: set afu_rst_n=1 and seq_done=1, go to RUN.
- RUN: steady state; outputs held.
- Abort applies in every state except WAIT_READY, and is triggered by ok=0 or soft_reset_req=1. On abort, the next edge sets all ss_rst_n=0, afu_rst_n=0, seq_done=0, idx=0, and state WAIT_READY. Abort takes priority over any same-cycle advance or ready.
- soft_reset_req is ignored in WAIT_READY.
- Already-released subsystems remain released until an abort. Resets are never released out of index order.
- timeout_err is cleared only by rst_n or on entry to HOLD.

## Timing
- Async input to ok: 2 cycles of synchronizer latency.
- First edge sampling ok=1 in WAIT_READY = E0:
  - ss_rst_n[0] rises after edge E(HOLD_CYCLES+1).
  - Each later subsystem release follows the previous ready sample by exactly 2 edges (SS_WAIT→SS_REL→release).
- A subsystem spends a minimum of 1 and a maximum of ACK_TIMEOUT cycles in SS_WAIT.
- afu_rst_n and seq_done rise together, 2 edges after the last subsystem's ready (or timeout) is sampled.
- Abort: all resets are low 1 edge after soft_reset_req is sampled, or 3 edges after an async input drops.
- All outputs are registered; no combinational paths from inputs to outputs.

## Test plan
Default configuration for all scenarios: NUM_SS=3, HOLD_CYCLES=16, ACK_TIMEOUT=64.
- Normal bring-up: all inputs go ready at once; each ss_ready rises 5 cycles after its ss_rst_n → ss_rst_n goes 001→011→111 in order; afu_rst_n=seq_done=1; timeout_err=0; seq_state=6.
- Timeout: ss_ready[1] held at 0 → after exactly 64 cycles in SS_WAIT, timeout_err=3'b010; ss_rst_n[2] is then released; seq_done=1.
- PERST# drop in RUN → within 3 cycles ss_rst_n=0, afu_rst_n=0, seq_done=0, seq_state=1. On re-assert, a full 16-cycle HOLD occurs and timeout_err clears on HOLD entry.
- pll_locked glitches low for 2 cycles while hold_cnt=10 → returns to WAIT_READY; no release occurs; HOLD restarts from 0.
- soft_reset_req pulse in SS_WAIT with idx=1 → next edge sets ss_rst_n=000 and seq_state=1, then re-sequences from index 0. A pulse while in WAIT_READY has no effect.
- rst_n asserted mid-SS_WAIT → all outputs take their reset values immediately, without a clock edge.
